sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Parametrised 3x3 window generator for the Sobel pipeline.
- Accepts a raster-order pixel stream (gray and RGB bypass) and emits one 3x3 window per pixel position, IMG_W*IMG_H windows per frame.
- Border pixels are filled by a runtime-selectable mode: zero or replicate.
- Flushes the last row internally at end of frame without extra input, and supplies frame/line sideband flags to the downstream convolution stage.

Parameters:
- IMG_W, 1920, pixels per line (>=2)
- IMG_H, 1080, lines per frame (>=2)
- PIX_W, 8, gray pixel width
- BYP_W, 24, bypass (RGB) width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- data_m_gray  in  PIX_W  input gray pixel
- data_m_rgb  in  BYP_W  input bypass pixel
- valid_m  in  1  input valid
- ready_m  out  1  input ready
- border_mode  in  1  0=zero fill, 1=replicate (clamp); sampled on first pixel of frame
- ready_s  in  1  downstream ready
- valid_s  out  1  window valid
- win_s  out  9*PIX_W  window; a(i+1)(j+1) at win_s[PIX_W*(3*i+j) +: PIX_W], i=row (0=top), j=col (0=left)
- data_s_rgb  out  BYP_W  bypass of centre pixel
- border_s  out  1  centre on first/last row or column
- sof_s  out  1  centre is (0,0)
- eol_s  out  1  centre column = IMG_W-1
- eof_s  out  1  centre is (IMG_H-1, IMG_W-1)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
  - Reset values: valid_s=0, win_s=0, data_s_rgb=0, border_s=0, sof_s=0, eol_s=0, eof_s=0, ready_m=0 during reset.
  - All counters and the latched mode clear to 0; the FSM goes to RUN.
  - Line-buffer RAM contents are not cleared; stale data is masked by border logic.
- Handshakes:
  - Input transfer when valid_m & ready_m.
  - Output transfer when valid_s & ready_s.
  - Single output register stage: it may load when ~valid_s | ready_s (call this adv).
  - ready_m = (state==RUN) & adv. ready_m is registered-free (combinational) from ready_s.
  - Outputs hold stable while valid_s & ~ready_s.
- Storage:
  - Two gray line buffers of IMG_W x PIX_W.
  - One bypass delay of IMG_W+1 entries x BYP_W.
  - 3x3 shift register array. It shifts only on input transfer (RUN) or on flush step (FLUSH).
- Counters: in_cnt 0..IMG_W*IMG_H-1; out_row 0..IMG_H-1; out_col 0..IMG_W-1.
- Latency and window emission:
  - The window centred at raster index k is loaded into the output register on the cycle that accepts input index k+IMG_W+1.
  - valid_s rises the following cycle.
  - The first IMG_W+1 accepted pixels of a frame produce no output.
- FSM:
  - RUN: accept input. On accepting index IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH:
    - ready_m=0.
    - Each cycle with adv, shift a dummy column and emit the next window; IMG_W+1 windows total, ending with eof_s=1.
    - When the eof window is transferred, return to RUN with all counters at 0.
    - ready_m may assert the cycle after the eof transfer.
- Border fill, per tap (centre at out_row/out_col):
  - Zero mode: any tap outside the image = 0.
  - Replicate mode: the tap row/col is clamped to [0, IMG_H-1] / [0, IMG_W-1] independently.
  - Applies to corners and to flush dummy data.
  - Window data never crosses line boundaries.
- border_mode is latched on acceptance of in_cnt==0 and held for the whole frame, including flush.
- Sideband flags are aligned with win_s and data_s_rgb. sof_s, eol_s and eof_s are valid only when valid_s=1 (0 otherwise).
- Input gaps (valid_m low) mid-frame: no shift, no emission, state held indefinitely.
- Reset mid-frame:
  - Any in-flight frame is discarded and the output is dropped (valid_s=0).
  - The next accepted pixel is treated as (0,0).
- Simultaneous output transfer and new load: the register reloads the same cycle, giving no bubble. Full throughput is 1 window/clk in steady state.

Test Plan:
- IMG_W=4, IMG_H=3, p(r,c)=4r+c+1, border_mode=0, ready_s=1, valid_m=1:
  - First valid_s the cycle after accepting pixel 6 (index 5).
  - Centre (0,0) win = 0,0,0,0,1,2,0,5,6; sof_s=1, border_s=1.
  - 12 windows total.
- Same image, border_mode=1:
  - Centre (0,0) win = 1,1,2,1,1,2,5,5,6.
  - Centre (1,1) win = 1,2,3,5,6,7,9,10,11 with border_s=0.
  - Centre (2,3) win = 7,8,8,11,12,12,11,12,12 with eof_s=1, eol_s=1.
- Flush, mode 0:
  - After the last input, ready_m=0 and 5 windows are emitted without input.
  - Last window = 7,8,0,11,12,0,0,0,0.
  - ready_m returns to 1 the cycle after the eof transfer.
- Backpressure:
  - Random ready_s (50%) and random valid_m gaps.
  - Window sequence is identical to the no-stall run.
  - Outputs are stable while stalled; no drops or duplicates; data_s_rgb equals the centre pixel RGB.
- Mode latch: toggle border_mode mid-frame -> results unchanged until the next frame's first pixel.
- Reset mid-frame:
  - Assert rst_n=0 for 1 cycle after 7 pixels -> valid_s=0 next cycle.
  - A fresh 12-pixel frame then yields the exact expected windows of test 1.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Stream interface for the Sobel 3x3 window generator: raster pixel input side
// and window output side, with the per-frame border mode select.
interface sobel_window_gen_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned BYP_W = 24
);
    logic [PIX_W-1:0]   data_m_gray;
    logic [BYP_W-1:0]   data_m_rgb;
    logic               valid_m;
    logic               ready_m;
    logic               border_mode;
    logic               ready_s;
    logic               valid_s;
    logic [9*PIX_W-1:0] win_s;
    logic [BYP_W-1:0]   data_s_rgb;
    logic               border_s;
    logic               sof_s;
    logic               eol_s;
    logic               eof_s;

    modport master (
        output data_m_gray, data_m_rgb, valid_m, border_mode, ready_s,
        input  ready_m, valid_s, win_s, data_s_rgb, border_s, sof_s, eol_s, eof_s
    );

    modport slave (
        input  data_m_gray, data_m_rgb, valid_m, border_mode, ready_s,
        output ready_m, valid_s, win_s, data_s_rgb, border_s, sof_s, eol_s, eof_s
    );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 window generator: two line buffers feed a column shift register; border taps
// are zeroed or clamped per frame, and the last row is flushed without input.
module sobel_window_gen #(
    parameter int unsigned IMG_W = 1920,
    parameter int unsigned IMG_H = 1080,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned BYP_W = 24
) (
    input logic              clk,
    input logic              rst_n,
    sobel_window_gen_if.slave bus
);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned PTR_W = $clog2(IMG_W + 1);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   in_cnt;
    logic [COL_W-1:0]   in_col;
    logic [PTR_W-1:0]   byp_ptr;
    logic [ROW_W-1:0]   out_row;
    logic [COL_W-1:0]   out_col;
    logic               mode_q;

    logic [PIX_W-1:0]   lb0 [IMG_W];
    logic [PIX_W-1:0]   lb1 [IMG_W];
    logic [BYP_W-1:0]   byp_mem [IMG_W+1];
    logic [PIX_W-1:0]   sr [3][2];

    logic               adv, accept, flush_step, shift, load, eof_xfer;
    logic               last_col, last_row;
    logic [PIX_W-1:0]   newcol [3];
    logic [PIX_W-1:0]   raw [3][3];
    logic [9*PIX_W-1:0] win_c;
    logic [BYP_W-1:0]   byp_rd;

    assign adv        = ~bus.valid_s | bus.ready_s;
    assign bus.ready_m = rst_n & (state == ST_RUN) & adv;
    assign accept     = bus.valid_m & bus.ready_m;
    // Once the eof window sits in the output register no further flush columns are shifted.
    assign flush_step = (state == ST_FLUSH) & adv & ~(bus.valid_s & bus.eof_s);
    assign shift      = accept | flush_step;
    assign load       = (accept & (in_cnt > CNT_W'(IMG_W))) | flush_step;
    assign eof_xfer   = bus.valid_s & bus.ready_s & bus.eof_s;
    assign last_col   = (out_col == COL_W'(IMG_W - 1));
    assign last_row   = (out_row == ROW_W'(IMG_H - 1));
    assign byp_rd     = byp_mem[byp_ptr];

    // Incoming column: two rows from the line buffers plus the live (or dummy) pixel.
    always_comb begin
        newcol[0] = lb1[in_col];
        newcol[1] = lb0[in_col];
        newcol[2] = (state == ST_RUN) ? bus.data_m_gray : '0;
        for (int i = 0; i < 3; i++) begin
            raw[i][0] = sr[i][0];
            raw[i][1] = sr[i][1];
            raw[i][2] = newcol[i];
        end
    end

    // Border fill: each tap is redirected to the centre row/col when it falls outside.
    always_comb begin
        win_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int ri;
                int cj;
                ri = i;
                cj = j;
                if ((i == 0 && out_row == '0) || (i == 2 && last_row)) ri = 1;
                if ((j == 0 && out_col == '0) || (j == 2 && last_col)) cj = 1;
                if ((ri != i || cj != j) && !mode_q)
                    win_c[PIX_W*(3*i+j) +: PIX_W] = '0;
                else
                    win_c[PIX_W*(3*i+j) +: PIX_W] = raw[ri][cj];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (accept && in_cnt == CNT_W'(NPIX - 1)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (eof_xfer) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Storage without reset: stale contents are always masked by the border logic.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[in_col]      <= bus.data_m_gray;
            lb1[in_col]      <= lb0[in_col];
            byp_mem[byp_ptr] <= bus.data_m_rgb;
        end
        if (shift) begin
            for (int i = 0; i < 3; i++) begin
                sr[i][0] <= sr[i][1];
                sr[i][1] <= newcol[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt         <= '0;
            in_col         <= '0;
            byp_ptr        <= '0;
            out_row        <= '0;
            out_col        <= '0;
            mode_q         <= 1'b0;
            bus.valid_s    <= 1'b0;
            bus.win_s      <= '0;
            bus.data_s_rgb <= '0;
            bus.border_s   <= 1'b0;
            bus.sof_s      <= 1'b0;
            bus.eol_s      <= 1'b0;
            bus.eof_s      <= 1'b0;
        end else begin
            if (accept) begin
                if (in_cnt == '0) mode_q <= bus.border_mode;
                in_cnt <= (in_cnt == CNT_W'(NPIX - 1)) ? '0 : in_cnt + 1'b1;
            end
            if (shift) begin
                in_col  <= (in_col == COL_W'(IMG_W - 1)) ? '0 : in_col + 1'b1;
                byp_ptr <= (byp_ptr == PTR_W'(IMG_W)) ? '0 : byp_ptr + 1'b1;
            end
            if (load) begin
                out_col <= last_col ? '0 : out_col + 1'b1;
                if (last_col) out_row <= last_row ? '0 : out_row + 1'b1;
                bus.valid_s    <= 1'b1;
                bus.win_s      <= win_c;
                bus.data_s_rgb <= byp_rd;
                bus.border_s   <= (out_row == '0) | last_row | (out_col == '0) | last_col;
                bus.sof_s      <= (out_row == '0) & (out_col == '0);
                bus.eol_s      <= last_col;
                bus.eof_s      <= last_row & last_col;
            end else if (bus.ready_s) begin
                bus.valid_s <= 1'b0;
                bus.sof_s   <= 1'b0;
                bus.eol_s   <= 1'b0;
                bus.eof_s   <= 1'b0;
            end
            if (eof_xfer) begin
                in_cnt  <= '0;
                in_col  <= '0;
                out_row <= '0;
                out_col <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x3 image: windows are predicted from the stored
// frame with clamp/zero arithmetic and compared on every output transfer.
module tb_sobel_window_gen;
    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
    localparam int unsigned N = W * H;

    logic clk;
    logic rst_n;

    sobel_window_gen_if #(.PIX_W(8), .BYP_W(24)) intf ();

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BYP_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  img_g   [N];
    logic [23:0] img_rgb [N];
    logic [71:0] cap_win [N];
    logic [3:0]  cap_flg [N];
    int n_cmp;
    int n_fail;
    int n_flush;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int a00, input int a01, input int a02,
                                          input int a10, input int a11, input int a12,
                                          input int a20, input int a21, input int a22);
        int v [9];
        logic [71:0] w;
        v = '{a00, a01, a02, a10, a11, a12, a20, a21, a22};
        w = '0;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(v[k]);
        return w;
    endfunction

    // Reference window: zero outside the image, or clamp row and column independently.
    function automatic logic [71:0] model_win(input int r, input int c, input bit mode);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int tr;
                int tc;
                tr = r + i - 1;
                tc = c + j - 1;
                if (tr < 0 || tr >= int'(H) || tc < 0 || tc >= int'(W)) begin
                    if (mode) begin
                        tr = (tr < 0) ? 0 : (tr >= int'(H)) ? int'(H) - 1 : tr;
                        tc = (tc < 0) ? 0 : (tc >= int'(W)) ? int'(W) - 1 : tc;
                        w[8*(3*i+j) +: 8] = img_g[tr*int'(W) + tc];
                    end
                end else begin
                    w[8*(3*i+j) +: 8] = img_g[tr*int'(W) + tc];
                end
            end
        end
        return w;
    endfunction

    function automatic logic [3:0] model_flg(input int r, input int c);
        logic b, s, l, e;
        b = (r == 0) || (r == int'(H) - 1) || (c == 0) || (c == int'(W) - 1);
        s = (r == 0) && (c == 0);
        l = (c == int'(W) - 1);
        e = (r == int'(H) - 1) && (c == int'(W) - 1);
        return {b, s, l, e};
    endfunction

    function automatic logic [103:0] snap_outputs();
        return {intf.valid_s, intf.win_s, intf.data_s_rgb,
                intf.border_s, intf.sof_s, intf.eol_s, intf.eof_s};
    endfunction

    task automatic fill_pattern();
        for (int k = 0; k < int'(N); k++) begin
            img_g[k]   = 8'(k + 1);
            img_rgb[k] = 24'($urandom);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(N); k++) begin
            img_g[k]   = 8'($urandom);
            img_rgb[k] = 24'($urandom);
        end
    endtask

    // Streams img_* as one frame and checks every window transferred downstream.
    task automatic run_frame(input bit stall, input bit mode, input bit toggle);
        int n_acc = 0;
        int n_out = 0;
        int cyc = 0;
        bit seen_valid = 0;
        bit prev_stall = 0;
        logic [103:0] snap = '0;
        n_flush = 0;
        while (n_out < int'(N) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) chk("hold_while_stalled", snap_outputs(), snap);
            if (!seen_valid && intf.valid_s) begin
                seen_valid = 1;
                chk("first_valid_latency", n_acc, W + 2);
            end
            if (!intf.valid_s)
                chk("flags_idle", {intf.sof_s, intf.eol_s, intf.eof_s}, 3'b000);
            intf.valid_m     = (n_acc < int'(N)) && (!stall || $urandom_range(0, 3) != 0);
            intf.data_m_gray = (n_acc < int'(N)) ? img_g[n_acc] : 8'($urandom);
            intf.data_m_rgb  = (n_acc < int'(N)) ? img_rgb[n_acc] : 24'($urandom);
            intf.border_mode = (n_acc == 0) ? mode : (toggle ? 1'($urandom) : mode);
            intf.ready_s     = !stall || ($urandom_range(0, 1) == 1);
            #1;
            if (n_acc == int'(N)) chk("ready_m_in_flush", intf.ready_m, 1'b0);
            if (intf.valid_s && intf.ready_s) begin
                chk($sformatf("win[%0d]", n_out), intf.win_s,
                    model_win(n_out / int'(W), n_out % int'(W), mode));
                chk($sformatf("rgb[%0d]", n_out), intf.data_s_rgb, img_rgb[n_out]);
                chk($sformatf("flags[%0d]", n_out),
                    {intf.border_s, intf.sof_s, intf.eol_s, intf.eof_s},
                    model_flg(n_out / int'(W), n_out % int'(W)));
                cap_win[n_out] = intf.win_s;
                cap_flg[n_out] = {intf.border_s, intf.sof_s, intf.eol_s, intf.eof_s};
                if (n_acc == int'(N)) n_flush++;
                n_out++;
            end
            if (intf.valid_m && intf.ready_m) n_acc++;
            prev_stall = intf.valid_s && !intf.ready_s;
            snap = snap_outputs();
        end
        chk("frame_windows_out", n_out, N);
        // The window loaded by the last accept plus IMG_W+1 flushed windows.
        chk("flush_window_count", n_flush, W + 2);
        @(negedge clk);
        intf.valid_m = 1'b0;
        intf.ready_s = 1'b1;
        #1;
        chk("ready_m_after_eof", intf.ready_m, 1'b1);
        chk("valid_s_after_eof", intf.valid_s, 1'b0);
    endtask

    initial begin
        int n;
        int cyc;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        intf.valid_m     = 1'b0;
        intf.data_m_gray = '0;
        intf.data_m_rgb  = '0;
        intf.border_mode = 1'b0;
        intf.ready_s     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid_s", intf.valid_s, 1'b0);
        chk("rst_win_s", intf.win_s, 72'h0);
        chk("rst_rgb", intf.data_s_rgb, 24'h0);
        chk("rst_flags", {intf.border_s, intf.sof_s, intf.eol_s, intf.eof_s}, 4'h0);
        chk("rst_ready_m", intf.ready_m, 1'b0);
        rst_n = 1'b1;

        // Directed pattern p(r,c)=4r+c+1, zero fill, no stalls.
        fill_pattern();
        run_frame(1'b0, 1'b0, 1'b0);
        chk("z_c00_win", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("z_c00_flags", cap_flg[0], 4'b1100);
        chk("z_last_win", cap_win[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));

        // Same image, replicate fill.
        run_frame(1'b0, 1'b1, 1'b0);
        chk("r_c00_win", cap_win[0], pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        chk("r_c11_win", cap_win[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chk("r_c11_border", cap_flg[5][3], 1'b0);
        chk("r_c23_win", cap_win[11], pack9(7, 8, 8, 11, 12, 12, 11, 12, 12));
        chk("r_c23_flags", cap_flg[11], 4'b1011);

        // Random pixels, random gaps/backpressure, border_mode toggled mid-frame.
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(1'b1, 1'($urandom), 1'b1);
        end

        // Reset after 7 accepted pixels, then a clean directed frame.
        fill_pattern();
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            intf.valid_m     = 1'b1;
            intf.data_m_gray = img_g[n];
            intf.data_m_rgb  = img_rgb[n];
            intf.border_mode = 1'b1;
            intf.ready_s     = 1'b1;
            #1;
            if (intf.ready_m) n++;
        end
        chk("pre_reset_accepts", n, 7);
        @(negedge clk);
        chk("pre_reset_valid_s", intf.valid_s, 1'b1);
        rst_n = 1'b0;
        intf.data_m_gray = img_g[7];
        #1;
        chk("reset_ready_m", intf.ready_m, 1'b0);
        @(negedge clk);
        chk("post_reset_valid_s", intf.valid_s, 1'b0);
        chk("post_reset_sof", intf.sof_s, 1'b0);
        rst_n = 1'b1;
        intf.valid_m = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0);
        chk("rst_c00_win", cap_win[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("rst_last_win", cap_win[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
